// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scanner.
//   HEX_SEG : 16-entry hex -> {g,f,e,d,c,b,a} code table (active-high)
//   SEG_OFF : active-high "all segments dark" code
//   DP_BIT  : bit position of the decimal point in an 8-bit segment code
package seg7_pkg;

    localparam int DP_BIT = 7;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Packed table, entry 15 written first so HEX_SEG[n] is the code for digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble -> segment code (active-high).
//   nib   in  4  hex value to show
//   dp    in  1  decimal point, ORed into bit DP_BIT
//   blank in  1  suppress the digit glyph (dp still honoured)
//   code  out 8  {dp,g,f,e,d,c,b,a}, 1 = lit
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] code
);

    always_comb begin
        code = SEG_OFF;
        if (!blank) begin
            code[6:0] = HEX_SEG[nib];
        end
        code[DP_BIT] = dp;
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed N-digit seven-segment scanner with leading-zero
// blanking, 16-level brightness PWM and frame-synchronous data update.
//   clk        in  1             system clock
//   rst_n      in  1             asynchronous reset, active low
//   idata      in  4*NUM_DIGITS  nibble per digit, top nibble = digit 0 (leftmost)
//   dp_in      in  NUM_DIGITS    decimal point per digit, MSB = digit 0
//   load       in  1             take idata/dp_in at the next frame boundary
//   blank_lz   in  1             suppress leading zeros
//   bright     in  4             on-time = (bright+1)/16 of each digit slot
//   seg_out    out 8             {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW_SEG
//   sel_out    out SEL_W         binary index of the digit being driven
//   frame_done out 1             one-cycle pulse as the scan wraps to digit 0
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_CYCLES    = 50000,
    parameter int SEL_W          = 3,
    parameter int ACTIVE_LOW_SEG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] idata,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [3:0]              bright,
    output logic [7:0]              seg_out,
    output logic [SEL_W-1:0]        sel_out,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SCAN_CYCLES);
    // Threshold can equal SCAN_CYCLES itself (bright=15), so size for that value.
    localparam int THR_W = $clog2(SCAN_CYCLES + 1);
    localparam int STEP  = SCAN_CYCLES / 16;
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [7:0] POL = (ACTIVE_LOW_SEG != 0) ? 8'hFF : 8'h00;

    logic [CNT_W-1:0]      cnt;
    logic [SEL_W-1:0]      idx;
    logic                  slot_end;
    logic                  frame_end;

    logic [DW-1:0]         stage_data, disp_data;
    logic [NUM_DIGITS-1:0] stage_dp, disp_dp;
    logic                  pend;
    logic [3:0]            bright_q;

    logic [3:0]            bright_eff;
    logic [THR_W-1:0]      thr;
    logic                  lit;

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] dig_dp;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [7:0]            code;
    logic [7:0]            seg_next;

    assign slot_end  = (cnt == CNT_W'(SCAN_CYCLES - 1));
    assign frame_end = slot_end && (idx == SEL_W'(NUM_DIGITS - 1));

    // Slot and digit counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= frame_end ? '0 : idx + SEL_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Double-buffered display data: disp only changes on a frame boundary.
    // A load landing exactly on the boundary bypasses stage so it is not a frame late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_data <= '0;
            stage_dp   <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            pend       <= 1'b0;
        end else if (frame_end) begin
            if (load) begin
                disp_data <= idata;
                disp_dp   <= dp_in;
                pend      <= 1'b0;
            end else if (pend) begin
                disp_data <= stage_data;
                disp_dp   <= stage_dp;
                pend      <= 1'b0;
            end
        end else if (load) begin
            stage_data <= idata;
            stage_dp   <= dp_in;
            pend       <= 1'b1;
        end
    end

    // Brightness is latched at slot start; the slot's first cycle uses the live value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= '0;
        end else if (cnt == '0) begin
            bright_q <= bright;
        end
    end

    assign bright_eff = (cnt == '0) ? bright : bright_q;
    assign thr        = THR_W'({1'b0, bright_eff} + 5'd1) * THR_W'(STEP);
    assign lit        = THR_W'(cnt) < thr;

    // Per-digit unpack and leading-zero mask; the running flag drops at the first
    // non-zero nibble, and the last digit is never blanked.
    always_comb begin
        logic lead_zero;
        lead_zero = blank_lz;
        lz_blank  = '0;
        dig_dp    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib[k]      = disp_data[4*(NUM_DIGITS-1-k) +: 4];
            dig_dp[k]   = disp_dp[NUM_DIGITS-1-k];
            lead_zero   = lead_zero && (nib[k] == 4'h0);
            lz_blank[k] = lead_zero && (k < NUM_DIGITS - 1);
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == SEL_W'(k)) begin
                cur_nib   = nib[k];
                cur_dp    = dig_dp[k];
                cur_blank = lz_blank[k];
            end
        end
    end

    seg7_hex_decode u_dec (
        .nib   (cur_nib),
        .dp    (cur_dp),
        .blank (cur_blank),
        .code  (code)
    );

    assign seg_next = lit ? code : SEG_OFF;

    // sel_out and seg_out are registered from the same idx/cnt so they never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= SEG_OFF ^ POL;
            sel_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_next ^ POL;
            sel_out    <= idx;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (6 digits, 16-cycle slots, active-low segments).
// A frame-position model predicts every output cycle from the behavioural rules.
module tb_seg7_scan_ctrl;

    localparam int N  = 6;
    localparam int S  = 16;
    localparam int FR = N * S;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] idata = '0;
    logic [5:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bright = 4'd15;
    logic [7:0]  seg_out;
    logic [2:0]  sel_out;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS     (N),
        .SCAN_CYCLES    (S),
        .SEL_W          (3),
        .ACTIVE_LOW_SEG (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .idata      (idata),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .seg_out    (seg_out),
        .sel_out    (sel_out),
        .frame_done (frame_done)
    );

    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Model: position within the frame plus the shown/pending data.
    int          pos;
    logic [23:0] m_disp, m_stage;
    logic [5:0]  m_disp_dp, m_stage_dp;
    bit          m_pend;
    int          m_bright;
    logic [7:0]  exp_seg;
    int          exp_sel;
    bit          exp_fd;

    function automatic logic [7:0] model_seg(int digit, int off, int br);
        logic [23:0] rest;
        logic [7:0]  c;
        rest = m_disp >> (4 * (N - 1 - digit));
        if (blank_lz && digit < N - 1 && rest == 24'h0) c = 8'h00;
        else c = hex_tab[rest[3:0]];
        if (m_disp_dp[N-1-digit]) c = c | 8'h80;
        if (off >= (br + 1) * (S / 16)) c = 8'h00;
        return ~c;
    endfunction

    task automatic model_reset();
        pos = 0;
        m_disp = '0; m_disp_dp = '0; m_stage = '0; m_stage_dp = '0;
        m_pend = 0; m_bright = 0;
        exp_seg = 8'hFF; exp_sel = 0; exp_fd = 0;
    endtask

    // Predict the outputs registered at the next edge from pre-edge inputs, then clock.
    task automatic step();
        int digit = pos / S;
        int off = pos % S;
        if (off == 0) m_bright = int'(bright);
        exp_seg = model_seg(digit, off, m_bright);
        exp_sel = digit;
        exp_fd  = (pos == FR - 1);
        if (pos == FR - 1) begin
            if (load) begin
                m_disp = idata; m_disp_dp = dp_in; m_pend = 0;
            end else if (m_pend) begin
                m_disp = m_stage; m_disp_dp = m_stage_dp; m_pend = 0;
            end
        end else if (load) begin
            m_stage = idata; m_stage_dp = dp_in; m_pend = 1;
        end
        pos = (pos + 1) % FR;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg_out !== 8'hFF || sel_out !== 3'd0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state seg=%h sel=%0d fd=%0d want FF/0/0", seg_out, sel_out, frame_done);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FR; i++) begin
            step();
            checks++;
            if (seg_out !== exp_seg || sel_out !== exp_sel[2:0] || frame_done !== exp_fd) begin
                failures++;
                $display("FAIL reset_frame seg=%h/%h sel=%0d/%0d fd=%0d/%0d",
                         seg_out, exp_seg, sel_out, exp_sel, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] want [6] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
        idata = 24'h123456; dp_in = '0; load = 1'b1;
        step();
        load = 1'b0;
        while (pos != 0) step();
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            checks++;
            if (seg_out !== exp_seg || sel_out !== exp_sel[2:0] || frame_done !== exp_fd ||
                seg_out !== want[sel_out]) begin
                failures++;
                $display("FAIL basic seg=%h/%h sel=%0d/%0d fd=%0d/%0d",
                         seg_out, exp_seg, sel_out, exp_sel, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_midframe_load();
        while (pos != 2 * S) step();
        idata = 24'hABCDEF; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            checks++;
            if (seg_out !== exp_seg || sel_out !== exp_sel[2:0] || frame_done !== exp_fd) begin
                failures++;
                $display("FAIL midframe_load seg=%h/%h sel=%0d/%0d fd=%0d/%0d",
                         seg_out, exp_seg, sel_out, exp_sel, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_boundary_load();
        while (pos != FR - 1) step();
        idata = 24'h000007; load = 1'b1;
        step();
        load = 1'b0;
        idata = 24'h999999;
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            checks++;
            if (seg_out !== exp_seg || sel_out !== exp_sel[2:0] || frame_done !== exp_fd) begin
                failures++;
                $display("FAIL boundary_load seg=%h/%h sel=%0d/%0d fd=%0d/%0d",
                         seg_out, exp_seg, sel_out, exp_sel, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_blanking();
        logic [23:0] vals [4];
        logic [5:0]  dps  [4];
        vals[0] = 24'h000120; dps[0] = 6'b000000;
        vals[1] = 24'h000000; dps[1] = 6'b000000;
        vals[2] = 24'h000000; dps[2] = 6'b000100;
        vals[3] = 24'($urandom_range(0, 24'h00FFFF)); dps[3] = 6'($urandom);
        blank_lz = 1'b1;
        for (int v = 0; v < 4; v++) begin
            idata = vals[v]; dp_in = dps[v]; load = 1'b1;
            step();
            load = 1'b0;
            for (int i = 0; i < 2 * FR; i++) begin
                step();
                checks++;
                if (seg_out !== exp_seg || sel_out !== exp_sel[2:0] || frame_done !== exp_fd) begin
                    failures++;
                    $display("FAIL blanking v=%0d seg=%h/%h sel=%0d/%0d fd=%0d/%0d",
                             v, seg_out, exp_seg, sel_out, exp_sel, frame_done, exp_fd);
                end
            end
        end
        blank_lz = 1'b0;
        dp_in = '0;
    endtask

    task automatic test_bright();
        idata = 24'h123456; load = 1'b1;
        step();
        load = 1'b0;
        bright = 4'd3;
        for (int i = 0; i < 2 * FR; i++) begin
            if (pos % S == 8 && (pos / S) == 2) bright = 4'd9;
            if (pos % S == 8 && (pos / S) == 4) bright = 4'(1 + $urandom_range(0, 13));
            step();
            checks++;
            if (seg_out !== exp_seg || sel_out !== exp_sel[2:0] || frame_done !== exp_fd) begin
                failures++;
                $display("FAIL bright seg=%h/%h sel=%0d/%0d fd=%0d/%0d",
                         seg_out, exp_seg, sel_out, exp_sel, frame_done, exp_fd);
            end
        end
        bright = 4'd15;
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FR; i++) begin
            load = ($urandom_range(0, 19) == 0);
            if (load) begin
                idata = 24'($urandom);
                dp_in = 6'($urandom);
                if ($urandom_range(0, 1) == 1) idata[23:12] = '0;
            end
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 29) == 0) bright = 4'($urandom);
            step();
            checks++;
            if (seg_out !== exp_seg || sel_out !== exp_sel[2:0] || frame_done !== exp_fd) begin
                failures++;
                $display("FAIL random seg=%h/%h sel=%0d/%0d fd=%0d/%0d",
                         seg_out, exp_seg, sel_out, exp_sel, frame_done, exp_fd);
            end
        end
        load = 1'b0;
        bright = 4'd15;
        blank_lz = 1'b0;
    endtask

    task automatic test_reset_midscan();
        while (pos != 3 * S + 7) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (seg_out !== 8'hFF || sel_out !== 3'd0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_midscan seg=%h sel=%0d fd=%0d want FF/0/0", seg_out, sel_out, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FR + S; i++) begin
            step();
            checks++;
            if (seg_out !== exp_seg || sel_out !== exp_sel[2:0] || frame_done !== exp_fd) begin
                failures++;
                $display("FAIL after_reset seg=%h/%h sel=%0d/%0d fd=%0d/%0d",
                         seg_out, exp_seg, sel_out, exp_sel, frame_done, exp_fd);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_midframe_load();
        test_boundary_load();
        test_blanking();
        test_bright();
        test_random();
        test_reset_midscan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
